// File: rtl/systolic_feed_ctrl_if.sv
// Command/status bundle between the top-level controller
// and the systolic feed sequencer.
interface systolic_feed_ctrl_if #(
    parameter int TILE_W = 8
);
    logic              start;
    logic [TILE_W-1:0] num_tiles;
    logic              abort;
    logic [6:0]        addr_serial_num;
    logic              busy;
    logic              data_valid;
    logic              mac_clear;
    logic [TILE_W-1:0] tile_idx;
    logic              tile_done;
    logic              done;

    modport master (
        output start,
        output num_tiles,
        output abort,
        input  addr_serial_num,
        input  busy,
        input  data_valid,
        input  mac_clear,
        input  tile_idx,
        input  tile_done,
        input  done
    );

    modport slave (
        input  start,
        input  num_tiles,
        input  abort,
        output addr_serial_num,
        output busy,
        output data_valid,
        output mac_clear,
        output tile_idx,
        output tile_done,
        output done
    );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Sweeps the skewed SRAM read index once per tile, then drains the
// array; emits aligned operand-valid and tile/job completion pulses.
module systolic_feed_ctrl #(
    parameter int SERIAL_MAX   = 126,
    parameter int IDLE_IDX     = 127,
    parameter int PIPE_LAT     = 2,
    parameter int DRAIN_CYCLES = 34,
    parameter int TILE_W       = 8
) (
    input logic                 clk,
    input logic                 srstn,
    systolic_feed_ctrl_if.slave bus
);
    localparam int              CW        = $clog2(DRAIN_CYCLES + 1);
    localparam int              TW1       = TILE_W + 1;
    localparam logic [6:0]      ADDR_LAST = 7'(SERIAL_MAX);
    localparam logic [6:0]      ADDR_IDLE = 7'(IDLE_IDX);
    localparam logic [CW-1:0]   CNT_LOAD  = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [6:0]          addr_q, addr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TILE_W-1:0]   tile_q, tile_d;
    logic [TILE_W-1:0]   ntiles_q, ntiles_d;
    logic [TILE_W:0]     tile_nxt;
    logic                busy_q, busy_d;
    logic                tdone_q, tdone_d;
    logic                done_q, done_d;
    logic [PIPE_LAT-1:0] vld_q, vld_d;
    logic [PIPE_LAT-1:0] clr_q, clr_d;
    logic                feed_now;
    logic                first_now;

    assign tile_nxt  = {1'b0, tile_q} + TW1'(1);
    assign feed_now  = (state_q == FEED);
    assign first_now = feed_now && (addr_q == 7'd0);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        tile_d   = tile_q;
        ntiles_d = ntiles_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ntiles_d = bus.num_tiles;
                    if (bus.num_tiles != '0) begin
                        state_d = FEED;
                        addr_d  = 7'd0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FEED: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = DRAIN;
                    addr_d  = ADDR_IDLE;
                    cnt_d   = CNT_LOAD;
                end else begin
                    addr_d = addr_q + 7'd1;
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    // wider compare keeps tile_idx from wrapping
                    if (tile_nxt < {1'b0, ntiles_q}) begin
                        state_d = FEED;
                        addr_d  = 7'd0;
                        tile_d  = tile_nxt[TILE_W-1:0];
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                tile_d  = '0;
            end
            default: begin
                state_d = IDLE;
                addr_d  = ADDR_IDLE;
                tile_d  = '0;
            end
        endcase

        if (bus.abort) begin
            state_d = IDLE;
            addr_d  = ADDR_IDLE;
            cnt_d   = '0;
            tile_d  = '0;
        end
    end

    always_comb begin
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        tdone_d = (state_d == DRAIN) && (cnt_d == '0);
        vld_d   = (vld_q << 1) | PIPE_LAT'(feed_now);
        clr_d   = (clr_q << 1) | PIPE_LAT'(first_now);
        if (bus.abort) begin
            vld_d = '0;
            clr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q  <= IDLE;
            addr_q   <= ADDR_IDLE;
            cnt_q    <= '0;
            tile_q   <= '0;
            ntiles_q <= '0;
            busy_q   <= 1'b0;
            tdone_q  <= 1'b0;
            done_q   <= 1'b0;
            vld_q    <= '0;
            clr_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            tile_q   <= tile_d;
            ntiles_q <= ntiles_d;
            busy_q   <= busy_d;
            tdone_q  <= tdone_d;
            done_q   <= done_d;
            vld_q    <= vld_d;
            clr_q    <= clr_d;
        end
    end

    assign bus.addr_serial_num = addr_q;
    assign bus.busy            = busy_q;
    assign bus.data_valid      = vld_q[PIPE_LAT-1];
    assign bus.mac_clear       = clr_q[PIPE_LAT-1];
    assign bus.tile_idx        = tile_q;
    assign bus.tile_done       = tdone_q;
    assign bus.done            = done_q;
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl: single/multi/empty jobs,
// abort, start filtering and mid-job reset.
module tb_systolic_feed_ctrl;
    localparam int TP = 161;

    logic clk;
    logic srstn;
    int   errs;
    int   checks;

    systolic_feed_ctrl_if #(.TILE_W(8)) bus ();

    systolic_feed_ctrl dut (
        .clk   (clk),
        .srstn (srstn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] addr;
        logic       busy;
        logic       dv;
        logic       mc;
        logic       td;
        logic       dn;
        logic [7:0] tile;
    } exp_t;

    // expected outputs t cycles after the accepting edge of an n-tile job
    function automatic exp_t model(int t, int n);
        exp_t e;
        int   k;
        int   r;
        k      = t / TP;
        r      = t % TP;
        e.addr = 7'd127;
        e.busy = 1'b0;
        e.dv   = 1'b0;
        e.mc   = 1'b0;
        e.td   = 1'b0;
        e.dn   = 1'b0;
        e.tile = 8'd0;
        if (t < TP * n) begin
            e.busy = 1'b1;
            e.tile = 8'(k);
            if (r < 127) e.addr = 7'(r);
            e.dv = (r >= 2) && (r <= 128);
            e.mc = (r == 2);
            e.td = (r == 160);
        end else if (t == TP * n) begin
            e.busy = 1'b1;
            e.dn   = 1'b1;
            e.tile = (n == 0) ? 8'd0 : 8'(n - 1);
        end
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        srstn         = 1'b0;
        bus.start     = 1'b1;
        bus.num_tiles = 8'd1;
        bus.abort     = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.addr_serial_num !== 7'd127) begin
            errs++;
            $display("FAIL reset addr got %0d want 127",
                     bus.addr_serial_num);
        end
        checks++;
        if ({bus.busy, bus.data_valid, bus.mac_clear,
             bus.tile_done, bus.done} !== 5'b0) begin
            errs++;
            $display("FAIL reset flags got %b want 00000",
                     {bus.busy, bus.data_valid, bus.mac_clear,
                      bus.tile_done, bus.done});
        end
        checks++;
        if (bus.tile_idx !== 8'd0) begin
            errs++;
            $display("FAIL reset tile got %0d want 0", bus.tile_idx);
        end
        srstn     = 1'b1;
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_idle busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_job(int n, bit hold);
        exp_t e;
        int   last;
        last          = hold ? TP * n + 1 : TP * n + 3;
        bus.start     = 1'b1;
        bus.num_tiles = 8'(n);
        tick();
        if (!hold) bus.start = 1'b0;
        bus.num_tiles = 8'(n + 2);
        for (int t = 0; t <= last; t++) begin
            e = model(t, n);
            checks++;
            if (bus.addr_serial_num !== e.addr) begin
                errs++;
                $display("FAIL job%0d t=%0d addr got %0d want %0d",
                         n, t, bus.addr_serial_num, e.addr);
            end
            checks++;
            if (bus.busy !== e.busy) begin
                errs++;
                $display("FAIL job%0d t=%0d busy got %b want %b",
                         n, t, bus.busy, e.busy);
            end
            checks++;
            if (bus.data_valid !== e.dv) begin
                errs++;
                $display("FAIL job%0d t=%0d valid got %b want %b",
                         n, t, bus.data_valid, e.dv);
            end
            checks++;
            if (bus.mac_clear !== e.mc) begin
                errs++;
                $display("FAIL job%0d t=%0d mac_clear got %b want %b",
                         n, t, bus.mac_clear, e.mc);
            end
            checks++;
            if (bus.tile_done !== e.td) begin
                errs++;
                $display("FAIL job%0d t=%0d tile_done got %b want %b",
                         n, t, bus.tile_done, e.td);
            end
            checks++;
            if (bus.done !== e.dn) begin
                errs++;
                $display("FAIL job%0d t=%0d done got %b want %b",
                         n, t, bus.done, e.dn);
            end
            checks++;
            if (bus.tile_idx !== e.tile) begin
                errs++;
                $display("FAIL job%0d t=%0d tile got %0d want %0d",
                         n, t, bus.tile_idx, e.tile);
            end
            tick();
        end
        if (hold) begin
            checks++;
            if ({bus.busy, bus.addr_serial_num, bus.tile_idx}
                !== {1'b1, 7'd0, 8'd0}) begin
                errs++;
                $display("FAIL hold_restart busy/addr/tile got %b/%0d/%0d want 1/0/0",
                         bus.busy, bus.addr_serial_num, bus.tile_idx);
            end
            bus.start = 1'b0;
            bus.abort = 1'b1;
            tick();
            bus.abort = 1'b0;
            tick();
        end
    endtask

    task automatic test_abort;
        int pulses;
        bus.start     = 1'b1;
        bus.num_tiles = 8'd2;
        tick();
        bus.start = 1'b0;
        repeat (TP + 50) tick();
        checks++;
        if ({bus.addr_serial_num, bus.tile_idx, bus.data_valid}
            !== {7'd50, 8'd1, 1'b1}) begin
            errs++;
            $display("FAIL abort_pre addr/tile/valid got %0d/%0d/%b want 50/1/1",
                     bus.addr_serial_num, bus.tile_idx, bus.data_valid);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if (bus.addr_serial_num !== 7'd127) begin
            errs++;
            $display("FAIL abort addr got %0d want 127",
                     bus.addr_serial_num);
        end
        checks++;
        if ({bus.busy, bus.data_valid, bus.mac_clear,
             bus.tile_done, bus.done} !== 5'b0) begin
            errs++;
            $display("FAIL abort flags got %b want 00000",
                     {bus.busy, bus.data_valid, bus.mac_clear,
                      bus.tile_done, bus.done});
        end
        checks++;
        if (bus.tile_idx !== 8'd0) begin
            errs++;
            $display("FAIL abort tile got %0d want 0", bus.tile_idx);
        end
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            pulses += int'(bus.done) + int'(bus.tile_done)
                    + int'(bus.busy) + int'(bus.data_valid);
            tick();
        end
        checks++;
        if (pulses !== 0) begin
            errs++;
            $display("FAIL abort_quiet activity got %0d want 0", pulses);
        end
        bus.abort     = 1'b1;
        bus.start     = 1'b1;
        bus.num_tiles = 8'd1;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        tick();
        checks++;
        if ({bus.busy, bus.addr_serial_num} !== {1'b0, 7'd127}) begin
            errs++;
            $display("FAIL abort_start busy/addr got %b/%0d want 0/127",
                     bus.busy, bus.addr_serial_num);
        end
    endtask

    task automatic test_reset_mid;
        bus.start     = 1'b1;
        bus.num_tiles = 8'd2;
        tick();
        bus.start = 1'b0;
        repeat (40) tick();
        checks++;
        if ({bus.addr_serial_num, bus.data_valid} !== {7'd40, 1'b1}) begin
            errs++;
            $display("FAIL rst_pre addr/valid got %0d/%b want 40/1",
                     bus.addr_serial_num, bus.data_valid);
        end
        srstn         = 1'b0;
        bus.start     = 1'b1;
        bus.num_tiles = 8'd1;
        tick();
        checks++;
        if ({bus.addr_serial_num, bus.tile_idx} !== {7'd127, 8'd0}) begin
            errs++;
            $display("FAIL rst_mid addr/tile got %0d/%0d want 127/0",
                     bus.addr_serial_num, bus.tile_idx);
        end
        checks++;
        if ({bus.busy, bus.data_valid, bus.mac_clear,
             bus.tile_done, bus.done} !== 5'b0) begin
            errs++;
            $display("FAIL rst_mid flags got %b want 00000",
                     {bus.busy, bus.data_valid, bus.mac_clear,
                      bus.tile_done, bus.done});
        end
        srstn = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.addr_serial_num, bus.data_valid}
            !== {1'b1, 7'd0, 1'b0}) begin
            errs++;
            $display("FAIL rst_release busy/addr/valid got %b/%0d/%b want 1/0/0",
                     bus.busy, bus.addr_serial_num, bus.data_valid);
        end
        tick();
        tick();
        checks++;
        if ({bus.data_valid, bus.mac_clear, bus.addr_serial_num}
            !== {1'b1, 1'b1, 7'd2}) begin
            errs++;
            $display("FAIL rst_restart valid/clr/addr got %b/%b/%0d want 1/1/2",
                     bus.data_valid, bus.mac_clear, bus.addr_serial_num);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        tick();
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        test_reset();
        test_job(1, 1'b0);
        test_job(3, 1'b0);
        test_job(0, 1'b0);
        test_abort();
        test_job(1, 1'b0);
        test_job(1, 1'b1);
        test_job(0, 1'b1);
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
